inv_key_stream: RTL and testbench
=================================

# inv_key_stream

Sequential AES-128 inverse key scheduler for the decryption datapath. It is loaded once with the final (round-10) round key and streams the round keys backwards, round 10 down to round 0, over a valid/ready handshake. It regenerates each earlier round key on the fly from the later one, instead of storing all 11 keys as the forward key expansion does. It feeds the inverse-cipher round logic, which consumes keys in reverse order.

## Interface
- size, 128, key width in bits; 128 is the only supported value, and any other value is an elaboration error.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a stream; sampled only when idle.
- keyin  in  size  round-10 key; sampled on the same edge as an accepted start.
- keyout  out  128  current round key, word 0 in bits [127:96].
- round  out  4  round number of keyout, from 10 down to 0.
- key_valid  out  1  keyout and round are valid.
- key_ready  in  1  consumer accepts keyout; a transfer happens when key_valid & key_ready.
- busy  out  1  a stream is in progress (state OUT).
- done  out  1  one-cycle pulse after round 0 has been transferred.

## Operation
- States:
  - IDLE: busy=0, key_valid=0.
  - OUT: busy=1, key_valid=1.
- IDLE -> OUT on start: load keyin into the key register and set the round register to 10.
- OUT with a transfer and round>0:
  - key register <= previous round key; round <= round-1; stay in OUT.
- OUT with a transfer and round==0: go to IDLE and assert done for 1 cycle.
- OUT with no transfer: hold keyout and round stable; key_valid stays 1 (no retraction).
- Previous-key computation, combinational from the current words w0..w3 with current round r:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
- RotWord is a left byte rotate. SubWord uses 4 forward AES S-boxes; this is the only S-box usage in the block.
- Rcon[r] for r=1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. The round-0 key is never used as a source.
- start while busy is ignored; keyin is ignored outside an accepted start.
- reset in any state: return to IDLE and clear all registers. Any stream in progress is abandoned and no done pulse is produced.
- reset and start in the same cycle: reset wins.

## Timing
- Reset values: keyout=0, round=0, key_valid=0, busy=0, done=0.
- start accepted at edge t: key_valid=1, round=10, keyout=keyin from cycle t+1.
- Throughput: 1 key per cycle while key_ready is held high. A full stream of 11 keys takes 11 cycles after the start latency.
- Transfer at edge t updates keyout and round for cycle t+1. Only registered values appear on keyout; there is no combinational path from key_ready to keyout.
- done is high for exactly the cycle after the round-0 transfer, with busy=0 and key_valid=0 in that same cycle.
- A start asserted in the done cycle is accepted, and key_valid returns high 1 cycle later.
- Critical path: S-box plus 3 XOR levels per cycle.

## Test plan
- FIPS-197 key: load keyin=d014f9a8c9ee2589e13f0cc8b6630ca6 and pulse start, holding key_ready=1. Required response:
  - round 10 keyout = d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 9 keyout = ac7766f319fadc2128d12941575c006e
  - round 1 keyout = a0fafe1788542cb123a339392a6c7605
  - round 0 keyout = 2b7e151628aed2a6abf7158809cf4f3c
  - done pulses exactly once, 12 cycles after start.
- Backpressure: same key, with key_ready toggled pseudo-randomly. Required: keyout and round are stable whenever key_valid=1 and key_ready=0, and the key sequence is identical to the first scenario.
- Start while busy: pulse start with a different keyin during round 6. Required: ignored, and the stream completes with the original values.
- Reset mid-stream: assert reset while round=4. Required: next cycle key_valid=0, busy=0, round=0, keyout=0, and no done pulse; a new start then streams correctly from round 10.
- Back-to-back: assert start in the done cycle with keyin=all-zero-key round-10 key b4ef5bcb3e92e21123e951cf6f8f188e. Required: streams down to round 0 keyout=00000000000000000000000000000000.
- Reset values: hold reset for 3 cycles with start=1. Required: all outputs stay at 0 for the whole reset period.

Source files
------------

// File: rtl/inv_key_stream.sv
// inv_key_stream: AES-128 inverse key scheduler, streams round keys 10 down to 0 over valid/ready.
module inv_key_stream #(
  parameter int size = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [size-1:0] keyin,
  output logic [127:0]    keyout,
  output logic [3:0]      round,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            busy,
  output logic            done
);
  if (size != 128) begin : g_bad_size
    $error("inv_key_stream: size must be 128");
  end
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Indexed by the round being undone; entries past 10 are never reached.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  typedef enum logic {IDLE, OUT} state_t;
  state_t       r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_done;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_sub;
  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_sub = {SBOX[w_p3[23:16]], SBOX[w_p3[15:8]], SBOX[w_p3[7:0]], SBOX[w_p3[31:24]]};
  assign w_p0  = w_w0 ^ w_sub ^ {RCON[r_round], 24'h0};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_state <= OUT;
          r_key   <= keyin;
          r_round <= 4'd10;
        end
      end else if (key_ready) begin
        if (r_round == 4'd0) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end else begin
          r_key   <= {w_p0, w_p1, w_p2, w_p3};
          r_round <= r_round - 4'd1;
        end
      end
    end
  end
  assign keyout    = r_key;
  assign round     = r_round;
  assign key_valid = (r_state == OUT);
  assign busy      = (r_state == OUT);
  assign done      = r_done;
endmodule

// File: tb/tb_inv_key_stream.sv
// tb_inv_key_stream: checks inv_key_stream against a forward key expansion built from GF(2^8) arithmetic.
module tb_inv_key_stream;
  logic         clk = 1'b0;
  logic         reset, start, key_ready;
  logic [127:0] keyin, keyout;
  logic [3:0]   round;
  logic         key_valid, busy, done;
  int           total = 0;
  int           bad = 0;
  logic [127:0] exp_keys [11];
  logic [127:0] got [11];
  inv_key_stream #(.size(128)) dut (
    .clk(clk), .reset(reset), .start(start), .keyin(keyin), .keyout(keyout),
    .round(round), .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] b = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) b = gmul(b, a);
    s = 8'h63;
    for (int n = 0; n < 5; n++) s ^= (n == 0) ? b : ((b << n) | (b >> (8 - n)));
    return s;
  endfunction
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0]), sbox_ref(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  // Streams exp_keys[10] down to 0; returns at the negedge where done is observed.
  task automatic stream(input bit pre, input bit rnd, input bit inject);
    int r = 10;
    int last_c = 0;
    bit hold = 0;
    bit injected = 0;
    logic [127:0] pk;
    logic [3:0]   pr;
    if (!pre) begin
      start = 1'b1;
      keyin = exp_keys[10];
    end
    for (int c = 1; c <= 200 && r >= 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      keyin = {$urandom, $urandom, $urandom, $urandom};
      if (c == 1) chk("valid_after_start", {127'b0, key_valid}, 128'd1);
      if (hold) begin
        chk("hold_key", keyout, pk);
        chk("hold_round", {124'b0, round}, {124'b0, pr});
      end
      chk("no_early_done", {127'b0, done}, 128'd0);
      if (inject && !injected && round == 4'd6) begin
        start = 1'b1;
        injected = 1;
      end
      key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = key_valid && !key_ready;
      pk = keyout;
      pr = round;
      if (key_valid && key_ready) begin
        chk($sformatf("round_%0d", r), {124'b0, round}, 128'(r));
        chk($sformatf("key_r%0d", r), keyout, exp_keys[r]);
        got[r] = keyout;
        r--;
        last_c = c;
      end
    end
    if (r >= 0) chk("stream_timeout", 128'(r), 128'h0 - 128'd1);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {127'b0, done}, 128'd1);
    chk("done_busy", {127'b0, busy}, 128'd0);
    chk("done_valid", {127'b0, key_valid}, 128'd0);
    if (!rnd) chk("done_latency", 128'(last_c + 1), 128'd12);
  endtask
  task automatic idle_after;
    @(negedge clk);
    chk("done_once", {127'b0, done}, 128'd0);
    chk("idle_valid", {127'b0, key_valid}, 128'd0);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b1;
    key_ready = 1'b1;
    keyin = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {keyout[127:8], keyout[7:0] | {round, key_valid, busy, done, 1'b0}}, 128'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {126'b0, key_valid, busy}, 128'd0);
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    stream(0, 0, 0);
    chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    idle_after();
    stream(0, 1, 0);
    chk("bp_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("bp_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    idle_after();
    expand({$urandom, $urandom, $urandom, $urandom});
    stream(0, 1, 1);
    idle_after();
    expand({$urandom, $urandom, $urandom, $urandom});
    start = 1'b1;
    keyin = exp_keys[10];
    key_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (round == 4'd4 && key_valid) break;
    end
    chk("pre_reset_round", {124'b0, round}, 128'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", {127'b0, key_valid}, 128'd0);
    chk("midrst_busy", {127'b0, busy}, 128'd0);
    chk("midrst_round", {124'b0, round}, 128'd0);
    chk("midrst_key", keyout, 128'd0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("midrst_no_done", {127'b0, done}, 128'd0);
    end
    stream(0, 0, 0);
    expand(128'd0);
    start = 1'b1;
    keyin = exp_keys[10];
    stream(1, 0, 0);
    chk("b2b_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("b2b_r0", got[0], 128'd0);
    idle_after();
    for (int n = 0; n < 3; n++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      stream(0, 1, 0);
      idle_after();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
